// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//
// Hazard controller for the 5-stage core. It holds or squashes pipeline
// stages around three situations: outstanding data-memory accesses,
// load-use hazards and taken branches. It also selects the operand-forward
// source for the instruction in ID. A MEM_WAIT state with a timeout counter
// aborts data-bus accesses that never get an acknowledge.
//
// Optional feature macro: HAZARD_STATS_EN
//   defined   -> stall_cnt_o counts cycles with stall_if_o high, saturating
//   undefined -> stall_cnt_o is tied to 0
//
// Parameters
//   MEM_TIMEOUT  max MEM_WAIT cycles before abort (0 disables the timeout)
//
// Ports
//   clk_i, rst_i                    clock, synchronous active-high reset
//   id_rs1_i, id_rs2_i              ID source registers
//   id_use_rs1_i, id_use_rs2_i      ID instruction reads rs1 / rs2
//   ex_rd_i, ex_we_i, ex_is_load_i  EX destination, write enable, is load
//   ex_branch_taken_i               branch/jump resolved taken in EX
//   mem_rd_i, mem_we_i              MEM destination and write enable
//   mem_req_i, mem_ack_i            data-bus request active / acknowledge
//   stall_if_o .. stall_mem_o       hold the corresponding stage register
//   flush_id_o                      squash IF/ID
//   bubble_ex_o                     load a NOP into ID/EX
//   fwd_sel_a_o, fwd_sel_b_o        0 regfile, 1 EX result, 2 MEM result
//   mem_err_o                       one-cycle pulse on timeout abort
//   stall_cnt_o                     stall-cycle statistics counter
//   dbg_state_o                     current FSM state (0 RUN, 1 MEM_WAIT)
//
// Handshake: the data bus is a request/acknowledge pair. A request with a
// same-cycle acknowledge completes without stalling; otherwise the pipeline
// is held until the cycle in which mem_ack_i is seen, and is released in
// that same cycle.
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic        id_use_rs1_i,
    input  logic        id_use_rs2_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        ex_we_i,
    input  logic        ex_is_load_i,
    input  logic        ex_branch_taken_i,
    input  logic [4:0]  mem_rd_i,
    input  logic        mem_we_i,
    input  logic        mem_req_i,
    input  logic        mem_ack_i,
    output logic        stall_if_o,
    output logic        stall_id_o,
    output logic        stall_ex_o,
    output logic        stall_mem_o,
    output logic        flush_id_o,
    output logic        bubble_ex_o,
    output logic [1:0]  fwd_sel_a_o,
    output logic [1:0]  fwd_sel_b_o,
    output logic        mem_err_o,
    output logic [31:0] stall_cnt_o,
    output logic        dbg_state_o
);

    // Wide enough to hold MEM_TIMEOUT; at least one bit when disabled.
    localparam int unsigned CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;

    logic          load_use;
    logic          timeout_hit;

    // -----------------------------------------------------------------------
    // Forwarding: EX result wins over MEM result. A load in EX has no data
    // yet, so it never forwards from EX.
    // -----------------------------------------------------------------------
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic [4:0] ex_rd,
                                           input logic       ex_we,
                                           input logic       ex_ld,
                                           input logic [4:0] mem_rd,
                                           input logic       mem_we);
        logic [1:0] sel;
        sel = 2'd0;
        if (rs == 5'd0) begin
            sel = 2'd0;
        end else if (rs == ex_rd && ex_we && !ex_ld) begin
            sel = 2'd1;
        end else if (rs == mem_rd && mem_we) begin
            sel = 2'd2;
        end
        return sel;
    endfunction

    always_comb begin
        fwd_sel_a_o = fwd_sel(id_rs1_i, ex_rd_i, ex_we_i, ex_is_load_i, mem_rd_i, mem_we_i);
        fwd_sel_b_o = fwd_sel(id_rs2_i, ex_rd_i, ex_we_i, ex_is_load_i, mem_rd_i, mem_we_i);
    end

    // Load-use: the loaded value is only available once the load reaches MEM.
    always_comb begin
        load_use = ex_is_load_i && ex_we_i && (ex_rd_i != 5'd0) &&
                   ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                    (id_use_rs2_i && (id_rs2_i == ex_rd_i)));
    end

    // The abort fires in the cycle where the counter would step onto
    // MEM_TIMEOUT-1, so mem_err_o lands on wait cycle MEM_TIMEOUT-1 counted
    // from the request cycle.
    always_comb begin
        timeout_hit = 1'b0;
        if (MEM_TIMEOUT != 0) begin
            timeout_hit = (32'(wait_cnt_q) + 32'd1) >= (MEM_TIMEOUT - 32'd1);
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state and control outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        stall_if_o  = 1'b0;
        stall_id_o  = 1'b0;
        stall_ex_o  = 1'b0;
        stall_mem_o = 1'b0;
        flush_id_o  = 1'b0;
        bubble_ex_o = 1'b0;
        mem_err_o   = 1'b0;

        unique case (state_q)
            RUN: begin
                if (mem_req_i && !mem_ack_i) begin
                    stall_if_o  = 1'b1;
                    stall_id_o  = 1'b1;
                    stall_ex_o  = 1'b1;
                    stall_mem_o = 1'b1;
                    state_d     = MEM_WAIT;
                    wait_cnt_d  = '0;
                end else if (ex_branch_taken_i) begin
                    // The ID instruction is wrong-path, so a load-use hazard
                    // against it is irrelevant.
                    flush_id_o  = 1'b1;
                    bubble_ex_o = 1'b1;
                end else if (load_use) begin
                    stall_if_o  = 1'b1;
                    stall_id_o  = 1'b1;
                    bubble_ex_o = 1'b1;
                end
            end

            MEM_WAIT: begin
                // EX is frozen here, so branch and load-use are picked up
                // again once back in RUN.
                if (mem_ack_i) begin
                    state_d = RUN;
                end else if (timeout_hit) begin
                    mem_err_o = 1'b1;
                    state_d   = RUN;
                end else begin
                    stall_if_o  = 1'b1;
                    stall_id_o  = 1'b1;
                    stall_ex_o  = 1'b1;
                    stall_mem_o = 1'b1;
                    if (wait_cnt_q != {CW{1'b1}}) begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign dbg_state_o = state_q;

    // -----------------------------------------------------------------------
    // Stall statistics
    // -----------------------------------------------------------------------
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_if_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Directed bench for hazard_ctrl with MEM_TIMEOUT = 16. Inputs change 1 ns
// after the rising edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2;
    logic        id_use_rs1, id_use_rs2;
    logic [4:0]  ex_rd;
    logic        ex_we, ex_is_load, ex_branch_taken;
    logic [4:0]  mem_rd;
    logic        mem_we, mem_req, mem_ack;
    logic        stall_if, stall_id, stall_ex, stall_mem;
    logic        flush_id, bubble_ex;
    logic [1:0]  fwd_sel_a, fwd_sel_b;
    logic        mem_err;
    logic [31:0] stall_cnt;
    logic        dbg_state;

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(.MEM_TIMEOUT(16)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .id_rs1_i          (id_rs1),
        .id_rs2_i          (id_rs2),
        .id_use_rs1_i      (id_use_rs1),
        .id_use_rs2_i      (id_use_rs2),
        .ex_rd_i           (ex_rd),
        .ex_we_i           (ex_we),
        .ex_is_load_i      (ex_is_load),
        .ex_branch_taken_i (ex_branch_taken),
        .mem_rd_i          (mem_rd),
        .mem_we_i          (mem_we),
        .mem_req_i         (mem_req),
        .mem_ack_i         (mem_ack),
        .stall_if_o        (stall_if),
        .stall_id_o        (stall_id),
        .stall_ex_o        (stall_ex),
        .stall_mem_o       (stall_mem),
        .flush_id_o        (flush_id),
        .bubble_ex_o       (bubble_ex),
        .fwd_sel_a_o       (fwd_sel_a),
        .fwd_sel_b_o       (fwd_sel_b),
        .mem_err_o         (mem_err),
        .stall_cnt_o       (stall_cnt),
        .dbg_state_o       (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Checking task
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge (input drive point).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = 5'd0; ex_we = 1'b0; ex_is_load = 1'b0; ex_branch_taken = 1'b0;
        mem_rd = 5'd0; mem_we = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic check_stalls(input string tag, input logic [3:0] exp);
        check(tag, {28'd0, stall_if, stall_id, stall_ex, stall_mem}, {28'd0, exp});
    endtask

    int exp_cnt;
    int err_cyc;

    initial begin
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
        settle();

        // Reset state
        check("rst_state", {31'd0, dbg_state}, 32'd0);
        check_stalls("rst_stalls", 4'b0000);
        check("rst_flush", {31'd0, flush_id}, 32'd0);
        check("rst_bubble", {31'd0, bubble_ex}, 32'd0);
        check("rst_err", {31'd0, mem_err}, 32'd0);
        check("rst_cnt", stall_cnt, 32'd0);

        // EX addi x5, ID reads x5 -> forward from EX, no stall
        tick();
        ex_rd = 5'd5; ex_we = 1'b1; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        settle();
        check("fwd_ex_a", {30'd0, fwd_sel_a}, 32'd1);
        check_stalls("fwd_ex_nostall", 4'b0000);
        check("fwd_ex_nobubble", {31'd0, bubble_ex}, 32'd0);

        // Same write only in MEM -> select 2
        tick();
        ex_we = 1'b0; ex_rd = 5'd0; mem_rd = 5'd5; mem_we = 1'b1;
        settle();
        check("fwd_mem_a", {30'd0, fwd_sel_a}, 32'd2);

        // x0 never forwards
        tick();
        id_rs1 = 5'd0; ex_rd = 5'd0; ex_we = 1'b1; mem_rd = 5'd0; mem_we = 1'b1;
        settle();
        check("fwd_x0_a", {30'd0, fwd_sel_a}, 32'd0);

        // EX wins over MEM on operand b
        tick();
        clear_inputs();
        ex_rd = 5'd6; ex_we = 1'b1; mem_rd = 5'd6; mem_we = 1'b1;
        id_rs2 = 5'd6; id_use_rs2 = 1'b1;
        settle();
        check("fwd_prio_b", {30'd0, fwd_sel_b}, 32'd1);

        // Load in EX, rs2 not used -> no load-use stall
        tick();
        clear_inputs();
        ex_rd = 5'd7; ex_we = 1'b1; ex_is_load = 1'b1; id_rs2 = 5'd7; id_use_rs2 = 1'b0;
        settle();
        check_stalls("lu_unused", 4'b0000);

        // Load-use: one cycle of stall_if/stall_id/bubble
        id_use_rs2 = 1'b1;
        settle();
        check_stalls("lu_stall", 4'b1100);
        check("lu_bubble", {31'd0, bubble_ex}, 32'd1);
        check("lu_fwd_b", {30'd0, fwd_sel_b}, 32'd0);

        // Load moved to MEM -> forward from MEM, no stall
        tick();
        ex_rd = 5'd0; ex_we = 1'b0; ex_is_load = 1'b0; mem_rd = 5'd7; mem_we = 1'b1;
        settle();
        check("lu_next_fwd_b", {30'd0, fwd_sel_b}, 32'd2);
        check_stalls("lu_next_nostall", 4'b0000);
        check("lu_next_nobubble", {31'd0, bubble_ex}, 32'd0);

        // Load-use with a taken branch -> flush wins
        tick();
        clear_inputs();
        ex_rd = 5'd7; ex_we = 1'b1; ex_is_load = 1'b1; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
        ex_branch_taken = 1'b1;
        settle();
        check("br_flush", {31'd0, flush_id}, 32'd1);
        check("br_bubble", {31'd0, bubble_ex}, 32'd1);
        check_stalls("br_nostall", 4'b0000);

        // Memory access, ack on the 4th cycle
        tick();
        clear_inputs();
        mem_req = 1'b1;
        settle();
        check_stalls("mw_c0", 4'b1111);
        tick();
        settle();
        check("mw_c1_state", {31'd0, dbg_state}, 32'd1);
        check_stalls("mw_c1", 4'b1111);
        tick();
        settle();
        check_stalls("mw_c2", 4'b1111);
        tick();
        mem_ack = 1'b1;
        settle();
        check_stalls("mw_c3_ack", 4'b0000);
        check("mw_c3_err", {31'd0, mem_err}, 32'd0);
        tick();
        mem_req = 1'b0; mem_ack = 1'b0;
        settle();
        check("mw_after_state", {31'd0, dbg_state}, 32'd0);

        // One load-use cycle plus three memory stall cycles so far
`ifdef HAZARD_STATS_EN
        exp_cnt = 4;
`else
        exp_cnt = 0;
`endif
        check("stats_cnt", stall_cnt, 32'(exp_cnt));

        // Same-cycle ack -> no stall, stay in RUN
        mem_req = 1'b1; mem_ack = 1'b1;
        settle();
        check_stalls("ack0_nostall", 4'b0000);
        tick();
        mem_req = 1'b0; mem_ack = 1'b0;
        settle();
        check("ack0_state", {31'd0, dbg_state}, 32'd0);

        // Timeout: 15 stall cycles, error on cycle 15
        mem_req = 1'b1;
        settle();
        check_stalls("to_c0", 4'b1111);
        for (int c = 1; c < 15; c++) begin
            tick();
            settle();
            check_stalls($sformatf("to_c%0d_stall", c), 4'b1111);
            check($sformatf("to_c%0d_err", c), {31'd0, mem_err}, 32'd0);
        end
        tick();
        settle();
        check("to_c15_err", {31'd0, mem_err}, 32'd1);
        check_stalls("to_c15_stall", 4'b0000);
        mem_req = 1'b0;
        tick();
        settle();
        check("to_after_state", {31'd0, dbg_state}, 32'd0);
        check("to_after_err", {31'd0, mem_err}, 32'd0);

        // Reset during MEM_WAIT at cycle 5
        mem_req = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
        end
        settle();
        check("rw_c5_state", {31'd0, dbg_state}, 32'd1);
        rst = 1'b1; mem_req = 1'b0;
        settle();
        check("rw_c5_err", {31'd0, mem_err}, 32'd0);
        tick();
        rst = 1'b0;
        settle();
        check("rw_after_state", {31'd0, dbg_state}, 32'd0);
        check_stalls("rw_after_stall", 4'b0000);
        check("rw_after_err", {31'd0, mem_err}, 32'd0);
        check("rw_cnt_cleared", stall_cnt, 32'd0);

        // Wait counter must start from zero again: abort lands on cycle 15
        mem_req = 1'b1;
        err_cyc = -1;
        for (int c = 0; c < 40; c++) begin
            settle();
            if (mem_err) begin
                err_cyc = c;
                break;
            end
            tick();
        end
        check("rw_retry_err_cycle", 32'(err_cyc), 32'd15);
        mem_req = 1'b0;
        tick();
        settle();
        check("rw_retry_state", {31'd0, dbg_state}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound
    initial begin
        #100000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage core. Sits beside the forwarding unit and sequences the pipeline around its limits: stalls on load-use hazards and outstanding data-memory accesses, flushes on taken branches, and drives the operand-forward selects. A wait-state machine with a timeout counter aborts hung memory accesses.

## Interface
- `MEM_TIMEOUT`, default 16: max MEM_WAIT cycles before abort; 0 disables the timeout.
- `clk_i`  in  1  clock
- `rst_i`  in  1  synchronous, active-high reset
- `id_rs1_i`, `id_rs2_i`  in  5  source registers of the instruction in ID
- `id_use_rs1_i`, `id_use_rs2_i`  in  1  the ID instruction reads rs1/rs2
- `ex_rd_i`  in  5  destination register in EX
- `ex_we_i`  in  1  EX writes rd
- `ex_is_load_i`  in  1  EX holds a load
- `ex_branch_taken_i`  in  1  branch/jump resolved taken in EX
- `mem_rd_i`  in  5  destination register in MEM
- `mem_we_i`  in  1  MEM writes rd
- `mem_req_i`  in  1  MEM stage has a data-bus access active
- `mem_ack_i`  in  1  data-bus acknowledge
- `stall_if_o`, `stall_id_o`, `stall_ex_o`, `stall_mem_o`  out  1  hold the stage register
- `flush_id_o`  out  1  squash IF/ID
- `bubble_ex_o`  out  1  load a NOP into ID/EX
- `fwd_sel_a_o`, `fwd_sel_b_o`  out  2  0 = regfile, 1 = EX result, 2 = MEM result
- `mem_err_o`  out  1  one-cycle pulse on memory timeout abort
- `stall_cnt_o`  out  32  stall-cycle counter (see Configuration)

## Operation
- States: RUN, MEM_WAIT. Reset -> RUN, wait counter 0, all outputs 0.
- Forward select, combinational in every state, per operand: if the register is x0 -> 0; else if it matches `ex_rd_i` with `ex_we_i` set and `ex_is_load_i` clear -> 1; else if it matches `mem_rd_i` with `mem_we_i` set -> 2; else 0. EX takes priority over MEM.
- Load-use hazard (LU): `ex_is_load_i` and `ex_we_i` set, `ex_rd_i` != 0, and `ex_rd_i` matches a used ID source.
- RUN, priority order:
  1. `mem_req_i` and not `mem_ack_i`: assert all four stalls; go to MEM_WAIT; clear the counter.
  2. `ex_branch_taken_i`: assert `flush_id_o` and `bubble_ex_o`. This overrides LU because the ID instruction is wrong-path.
  3. LU: assert `stall_if_o`, `stall_id_o`, `bubble_ex_o` for one cycle. The next cycle the load is in MEM and is served by select 2.
  4. Otherwise no control asserted.
- MEM_WAIT:
  - While `mem_ack_i` is low, assert all four stalls and increment the counter.
  - On `mem_ack_i`: drop stalls in that cycle and return to RUN.
  - If `MEM_TIMEOUT` != 0 and the counter reaches `MEM_TIMEOUT-1` with no ack: pulse `mem_err_o`, drop stalls, return to RUN.
  - Branch and LU are not evaluated. They re-evaluate in RUN because EX is held.
- Counter width is clog2(`MEM_TIMEOUT`+1) and it never wraps.

## Timing
- Stall, flush and bubble outputs are combinational from state and current inputs, with zero-cycle latency. The state and counter are registered.
- Same-cycle ack with request: no stall, stay in RUN.
- Ack arriving on cycle N of MEM_WAIT: stalls are high for cycles 0..N-1 and low at N; the state is RUN at N+1.
- Timeout: `mem_err_o` is high exactly on MEM_WAIT cycle `MEM_TIMEOUT-1` and low otherwise.
- `rst_i` during MEM_WAIT: the next edge returns to RUN with the counter cleared and no `mem_err_o`. Reset overrides every other input.

## Configuration
- `HAZARD_STATS_EN` defined: `stall_cnt_o` increments on every cycle in which `stall_if_o` is high. It saturates at 0xFFFFFFFF and clears on reset.
- `HAZARD_STATS_EN` undefined: the counter logic is omitted and `stall_cnt_o` is tied to 0.

## Test plan
- EX `addi x5` (we=1, not load), ID reads rs1=x5 -> `fwd_sel_a_o`=1, no stall. The same write from MEM only -> sel=2. rs=x0 with rd=x0 -> sel=0.
- EX load rd=x7, ID uses rs2=x7 -> one cycle of `stall_if_o`=`stall_id_o`=`bubble_ex_o`=1. Next cycle, with rd now in MEM -> `fwd_sel_b_o`=2, no stall.
- LU together with `ex_branch_taken_i` -> `flush_id_o`=1, `bubble_ex_o`=1, `stall_if_o`=0.
- `mem_req_i`=1 with ack arriving on the 4th cycle -> stalls high for 3 cycles, low on the ack cycle, state RUN. With ack in the request cycle -> no stall.
- `MEM_TIMEOUT`=16, ack never arrives -> 15 stall cycles, `mem_err_o` pulses on cycle 15, then RUN. `rst_i` at cycle 5 -> no `mem_err_o` and stalls drop after the edge.
- With `HAZARD_STATS_EN` defined, after the 3-cycle memory stall plus one LU -> `stall_cnt_o`=4.
